// File: rtl/ysyx_25060170_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, fill/overflow constants and operand-signedness helpers.
package ysyx_25060170_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Wide constants; modules slice them down to their own WIDTH.
  localparam int unsigned MDU_MAX_WIDTH = 64;
  localparam logic [MDU_MAX_WIDTH-1:0] MDU_ALL_ONES = '1;
  localparam logic [MDU_MAX_WIDTH-1:0] MDU_ALL_ZERO = '0;
  localparam logic [MDU_MAX_WIDTH-1:0] MDU_LSB_ONE  = 64'd1;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op1_signed(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op2_signed(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/ysyx_25060170_mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module ysyx_25060170_DIV_STEP #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/ysyx_25060170_mdu.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring step per
// cycle on operand magnitudes. Define YSYX_25060170_MDU_EARLY_OUT_EN to skip
// CALC for zero operands, divide-by-zero and signed overflow.
module ysyx_25060170_mdu
  import ysyx_25060170_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_1,
  input  logic [WIDTH-1:0] op_2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ZERO_W    = MDU_ALL_ZERO[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONES_W    = MDU_ALL_ONES[WIDTH-1:0];
  localparam logic [WIDTH-1:0] OVF_OP1   = WIDTH'(MDU_LSB_ONE << (WIDTH-1));
  localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'(WIDTH-1);

  mdu_state_e         state;
  mdu_op_e            op_q;
  mdu_op_e            op_in;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   op1_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               neg_q;
  logic               rem_neg_q;
  logic               dbz_q;
  logic               ovf_q;

  logic               s1, s2;
  logic [WIDTH-1:0]   m1, m2;
  logic               in_dbz, in_ovf;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem;
  logic               div_q;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fin_res;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    op_in  = mdu_op_e'(op);
    s1     = op1_signed(op_in) & op_1[WIDTH-1];
    s2     = op2_signed(op_in) & op_2[WIDTH-1];
    m1     = s1 ? (ZERO_W - op_1) : op_1;
    m2     = s2 ? (ZERO_W - op_2) : op_2;
    in_dbz = op_is_div(op_in) && (op_2 == ZERO_W);
    in_ovf = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
             (op_1 == OVF_OP1) && (op_2 == ONES_W);
  end

  // acc is {product_hi, multiplier} for multiply, {remainder, dividend} for divide.
  ysyx_25060170_DIV_STEP #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem          (acc[2*WIDTH-1:WIDTH]),
    .dividend_bit (acc[WIDTH-1]),
    .divisor      (a_q),
    .rem_next     (div_rem),
    .q_bit        (div_q)
  );

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_q : ZERO_W)};
    if (op_is_div(op_q)) begin
      acc_nxt = {div_rem, acc[WIDTH-2:0], div_q};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? ('0 - acc_nxt) : acc_nxt;
    quot_fix = neg_q ? (ZERO_W - acc_nxt[WIDTH-1:0]) : acc_nxt[WIDTH-1:0];
    rem_fix  = rem_neg_q ? (ZERO_W - acc_nxt[2*WIDTH-1:WIDTH]) : acc_nxt[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:                       fin_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fin_res = dbz_q ? ONES_W : (ovf_q ? OVF_OP1 : quot_fix);
      default:                      fin_res = dbz_q ? op1_q  : (ovf_q ? ZERO_W  : rem_fix);
    endcase
  end

`ifdef YSYX_25060170_MDU_EARLY_OUT_EN
  logic             early_hit;
  logic [WIDTH-1:0] early_res;

  // Every case that skips CALC has a result known from the raw operands.
  always_comb begin
    early_hit = 1'b0;
    early_res = ZERO_W;
    if (op_is_div(op_in)) begin
      early_hit = in_dbz || in_ovf || (op_1 == ZERO_W);
      if (in_dbz) begin
        early_res = op_is_rem(op_in) ? op_1 : ONES_W;
      end else if (in_ovf) begin
        early_res = op_is_rem(op_in) ? ZERO_W : OVF_OP1;
      end
    end else begin
      early_hit = (op_1 == ZERO_W) || (op_2 == ZERO_W);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      op_q      <= OP_MUL;
      a_q       <= '0;
      op1_q     <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q      <= op_in;
            op1_q     <= op_1;
            neg_q     <= s1 ^ s2;
            rem_neg_q <= s1;
            dbz_q     <= in_dbz;
            ovf_q     <= in_ovf;
            cnt       <= '0;
            if (op_is_div(op_in)) begin
              acc <= {ZERO_W, m1};
              a_q <= m2;
            end else begin
              acc <= {ZERO_W, m2};
              a_q <= m1;
            end
`ifdef YSYX_25060170_MDU_EARLY_OUT_EN
            if (early_hit) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              result    <= early_res;
            end else begin
              state <= ST_CALC;
            end
`else
            state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + WIDTH'(1);
            if (cnt == LAST_STEP) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              result    <= fin_res;
            end
          end
        end
        ST_DONE: begin
          if (flush || out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_mdu.sv
// Directed bench for ysyx_25060170_mdu: a vector table of hand-computed
// results and latencies, then stall, flush and mid-operation reset sequences.
module tb_ysyx_25060170_mdu;
  import ysyx_25060170_mdu_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned NVEC = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] op_1;
  logic [W-1:0] op_2;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          early;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  ysyx_25060170_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_1      (op_1),
    .op_2      (op_2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input bit early);
`ifdef YSYX_25060170_MDU_EARLY_OUT_EN
    return early ? 0 : 32;
`else
    return early ? 32 : 32;
`endif
  endfunction

  // Present a request for one cycle, then scramble the inputs after acceptance.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("in_ready before request", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op       = o;
    op_1     = a;
    op_2     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    op_1     = $urandom;
    op_2     = $urandom;
  endtask

  // Edges after the accept edge until out_valid is seen; 0 = right after accept.
  task automatic wait_valid(output int lat);
    lat = -1;
    if (out_valid) begin
      lat = 0;
    end else begin
      for (int k = 1; k <= 100; k++) begin
        @(posedge clk);
        #1;
        if (out_valid) begin
          lat = k;
          break;
        end
      end
    end
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " out_valid after take"}, {31'd0, out_valid}, 32'd0);
    check({name, " in_ready after take"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(o, a, b);
    wait_valid(lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, result, exp);
    consume(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic seen;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{OP_MUL,    32'h1234_5678,  32'h10,        32'h2345_6780, 1'b0};
    vecs[5]  = '{OP_MULHU,  32'h8000_0000,  32'd4,         32'h0000_0002, 1'b0};
    vecs[6]  = '{OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[7]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[8]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{OP_DIVU,   32'd100,        32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{OP_REMU,   32'd100,        32'd0,         32'd100,       1'b1};
    vecs[12] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[13] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[14] = '{OP_DIV,    32'd100,        32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[15] = '{OP_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1'b1};
    vecs[16] = '{OP_DIVU,   32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, 1'b0};
    vecs[17] = '{OP_REMU,   32'hFFFF_FFFF,  32'h10,        32'h0000_000F, 1'b0};
    vecs[18] = '{OP_DIV,    32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD, 1'b0};
    vecs[19] = '{OP_REM,    32'd20,         32'hFFFF_FFFA, 32'h0000_0002, 1'b0};
    vecs[20] = '{OP_MUL,    32'd0,          32'd5,         32'h0000_0000, 1'b1};
    vecs[21] = '{OP_DIV,    32'd0,          32'd7,         32'h0000_0000, 1'b1};
    vecs[22] = '{OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[23] = '{OP_MULH,   32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 1'b0};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = 3'd0; op_1 = '0; op_2 = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset busy",      {31'd0, busy},      32'd0);
    check("reset result",    result,             32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp, exp_latency(vecs[i].early));
    end

    // Consumer stalls for 10 cycles in DONE.
    start_op(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    wait_valid(lat);
    check("stall latency", 32'(lat), 32'd32);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("stall out_valid", {31'd0, out_valid}, 32'd1);
      check("stall result", result, 32'hFFFF_FFEB);
    end
    check("stall busy", {31'd0, busy}, 32'd1);
    consume("stall");

    // Flush during the fifth CALC cycle.
    start_op(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("flush busy before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush calc in_ready",  {31'd0, in_ready},  32'd1);
    check("flush calc busy",      {31'd0, busy},      32'd0);
    check("flush calc out_valid", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check("flush calc no result", {31'd0, seen}, 32'd0);

    // Flush while idle does nothing.
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush idle in_ready", {31'd0, in_ready}, 32'd1);
    check("flush idle busy",     {31'd0, busy},     32'd0);
    run_op("after idle flush", OP_MUL, 32'd6, 32'd7, 32'd42, 32);

    // Flush beats out_ready in DONE.
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_valid(lat);
    check("done flush latency", 32'(lat), 32'd32);
    check("done flush pre result", result, 32'd14);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b0;
    check("done flush out_valid", {31'd0, out_valid}, 32'd0);
    check("done flush in_ready",  {31'd0, in_ready},  32'd1);
    run_op("after done flush", OP_REMU, 32'd100, 32'd7, 32'd2, 32);

    // Reset pulse in the middle of CALC.
    start_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid rst busy",      {31'd0, busy},      32'd0);
    check("mid rst in_ready",  {31'd0, in_ready},  32'd1);
    check("mid rst result",    result,             32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check("no stale result after rst", {31'd0, seen}, 32'd0);
    run_op("mul after rst", OP_MUL, 32'd3, 32'd4, 32'd12, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
